ipv4_vlg_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the single IPv4 TX path between N protocol clients (e.g. ICMP, UDP, TCP).
- Latches the winning client's header fields and presents the packet to IPv4 TX.
- Muxes the payload stream while that packet is in flight.
- Returns accept, done and error status to the owning client.
- Sits between the protocol engines and the IPv4 TX instance, in the same clock domain.

---
 rtl/ipv4_vlg_tx_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_ipv4_vlg_tx_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_vlg_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ipv4_vlg_tx_arb
// Purpose  : Round-robin arbiter/sequencer sharing one IPv4 TX path among N
//            protocol clients. Define IPV4_VLG_TX_ARB_PRIO_EN for strict
//            fixed priority (lowest index wins) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module ipv4_vlg_tx_arb #(
    parameter int N       = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    cli_pend,
    input  logic [N*32-1:0] cli_ip,
    input  logic [N*8-1:0]  cli_proto,
    input  logic [N*16-1:0] cli_len,
    input  logic [N*8-1:0]  cli_dat,
    input  logic [N-1:0]    cli_val,
    output logic [N-1:0]    cli_req,
    output logic [N-1:0]    cli_acc,
    output logic [N-1:0]    cli_done,
    output logic [N-1:0]    cli_err,
    output logic            tx_pend,
    output logic [31:0]     tx_ip,
    output logic [7:0]      tx_proto,
    output logic [15:0]     tx_len,
    input  logic            tx_req,
    output logic [7:0]      tx_dat,
    output logic            tx_val,
    input  logic            tx_busy,
    input  logic            tx_done,
    input  logic            tx_err
);

    localparam int c_IW = $clog2(N);
    localparam int c_TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_XFER  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_IW-1:0]   r_gnt;
    logic [c_IW-1:0]   r_ptr;
    logic [c_IW-1:0]   w_win;
    logic [c_IW-1:0]   w_gnt_inc;
    logic              w_any;
    logic [15:0]       r_cnt;
    logic [c_TW-1:0]   r_tmo;
    logic [31:0]       r_ip;
    logic [7:0]        r_proto;
    logic [15:0]       r_len;
    logic [N-1:0]      r_acc;
    logic [N-1:0]      r_done;
    logic [N-1:0]      r_err;
    logic [N-1:0]      w_gnt_oh;
    logic              w_acc_set;
    logic              w_done_set;
    logic              w_err_set;
    logic              w_abort;
    logic              w_xfer;
    logic              w_last;

    logic [31:0]       w_ip_a    [N];
    logic [7:0]        w_proto_a [N];
    logic [15:0]       w_len_a   [N];
    logic [7:0]        w_dat_a   [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cli
            assign w_ip_a[gi]    = cli_ip[gi*32 +: 32];
            assign w_proto_a[gi] = cli_proto[gi*8 +: 8];
            assign w_len_a[gi]   = cli_len[gi*16 +: 16];
            assign w_dat_a[gi]   = cli_dat[gi*8 +: 8];
        end
    endgenerate

    // Winner selection among pending clients
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
`ifdef IPV4_VLG_TX_ARB_PRIO_EN
        for (int k = N - 1; k >= 0; k--) begin
            if (cli_pend[k]) begin
                w_win = c_IW'(k);
                w_any = 1'b1;
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            logic [c_IW:0] v_idx;
            v_idx = {1'b0, r_ptr} + (c_IW+1)'(k);
            // explicit wrap so non-power-of-two N rotates correctly
            if (v_idx >= (c_IW+1)'(N)) begin
                v_idx = v_idx - (c_IW+1)'(N);
            end
            if (!w_any && cli_pend[v_idx[c_IW-1:0]]) begin
                w_win = v_idx[c_IW-1:0];
                w_any = 1'b1;
            end
        end
`endif
    end

    assign w_xfer    = (r_state == S_XFER);
    assign w_gnt_oh  = {{(N-1){1'b0}}, 1'b1} << r_gnt;
    assign w_gnt_inc = (r_gnt == c_IW'(N - 1)) ? '0 : r_gnt + 1'b1;
    assign w_last    = tx_val && (({1'b0, r_cnt} + 17'd1) == {1'b0, r_len});
    assign w_abort   = (r_state != S_IDLE) &&
                       (tx_err || (r_tmo == c_TW'(TIMEOUT - 1)));

    assign tx_pend  = (r_state == S_GRANT);
    assign tx_ip    = r_ip;
    assign tx_proto = r_proto;
    assign tx_len   = r_len;
    assign tx_val   = w_xfer & cli_val[r_gnt];
    assign tx_dat   = w_xfer ? w_dat_a[r_gnt] : 8'd0;
    assign cli_req  = (w_xfer && tx_req) ? w_gnt_oh : '0;
    assign cli_acc  = r_acc;
    assign cli_done = r_done;
    assign cli_err  = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_set   = 1'b0;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (tx_busy) begin
                    w_acc_set   = 1'b1;
                    w_state_nxt = (r_len == 16'd0) ? S_WAIT : S_XFER;
                end
            end
            S_XFER: begin
                if (w_last) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // abort overrides acceptance and completion in the same cycle
        if (w_abort) begin
            w_acc_set   = 1'b0;
            w_done_set  = 1'b0;
            w_err_set   = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cnt   <= 16'd0;
            r_tmo   <= '0;
            r_ip    <= 32'd0;
            r_proto <= 8'd0;
            r_len   <= 16'd0;
            r_acc   <= '0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_gnt   <= w_win;
                r_ip    <= w_ip_a[w_win];
                r_proto <= w_proto_a[w_win];
                r_len   <= w_len_a[w_win];
            end

            if (w_acc_set) begin
                r_cnt <= 16'd0;
            end else if (w_xfer && tx_val) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_state_nxt != r_state || r_state == S_IDLE) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (w_done_set || w_err_set) begin
`ifdef IPV4_VLG_TX_ARB_PRIO_EN
                r_ptr <= '0;
`else
                r_ptr <= w_gnt_inc;
`endif
            end

            r_acc  <= w_acc_set  ? w_gnt_oh : '0;
            r_done <= w_done_set ? w_gnt_oh : '0;
            r_err  <= w_err_set  ? w_gnt_oh : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ipv4_vlg_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ipv4_vlg_tx_arb
// Purpose  : Scoreboard bench for ipv4_vlg_tx_arb (N=3, TIMEOUT=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipv4_vlg_tx_arb;

    localparam int N  = 3;
    localparam int TO = 100;
`ifdef IPV4_VLG_TX_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    localparam logic [2:0] K_PEND = 3'd1;
    localparam logic [2:0] K_ACC  = 3'd2;
    localparam logic [2:0] K_BYTE = 3'd3;
    localparam logic [2:0] K_DONE = 3'd4;
    localparam logic [2:0] K_ERR  = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [2:0]  cli;
        logic [31:0] ip;
        logic [7:0]  proto;
        logic [15:0] len;
        logic [7:0]  dat;
    } ev_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    cli_pend;
    logic [N*32-1:0] cli_ip;
    logic [N*8-1:0]  cli_proto;
    logic [N*16-1:0] cli_len;
    logic [N*8-1:0]  cli_dat;
    logic [N-1:0]    cli_val;
    logic [N-1:0]    cli_req;
    logic [N-1:0]    cli_acc;
    logic [N-1:0]    cli_done;
    logic [N-1:0]    cli_err;
    logic            tx_pend;
    logic [31:0]     tx_ip;
    logic [7:0]      tx_proto;
    logic [15:0]     tx_len;
    logic            tx_req;
    logic [7:0]      tx_dat;
    logic            tx_val;
    logic            tx_busy;
    logic            tx_done;
    logic            tx_err;

    logic [31:0] ip_a [N];
    logic [7:0]  pr_a [N];
    logic [15:0] ln_a [N];
    logic [3:0]  bidx [N];

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  own    = 0;
    int  ord [6];

    ipv4_vlg_tx_arb #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cli_pend(cli_pend), .cli_ip(cli_ip), .cli_proto(cli_proto),
        .cli_len(cli_len), .cli_dat(cli_dat), .cli_val(cli_val),
        .cli_req(cli_req), .cli_acc(cli_acc), .cli_done(cli_done),
        .cli_err(cli_err), .tx_pend(tx_pend), .tx_ip(tx_ip),
        .tx_proto(tx_proto), .tx_len(tx_len), .tx_req(tx_req),
        .tx_dat(tx_dat), .tx_val(tx_val), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Client models: byte j of client c is {c, j}; data offered whenever requested
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cli_ip[i*32 +: 32]   = ip_a[i];
            cli_proto[i*8 +: 8]  = pr_a[i];
            cli_len[i*16 +: 16]  = ln_a[i];
            cli_dat[i*8 +: 8]    = {4'(i), bidx[i]};
        end
    end
    assign cli_val = cli_req;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst || tx_pend) begin
                bidx[i] <= 4'd0;
            end else if (cli_req[i] && cli_val[i]) begin
                bidx[i] <= bidx[i] + 4'd1;
            end
        end
    end

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic ev_t ev(input logic [2:0] k, input int c, input logic [7:0] d);
        ev_t e;
        e      = '0;
        e.kind = k;
        e.cli  = 3'(c);
        e.dat  = d;
        return e;
    endfunction

    function automatic int idx(input logic [N-1:0] v);
        int r;
        r = 7;
        if ($onehot(v)) begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) r = i;
            end
        end
        return r;
    endfunction

    function automatic void got(input ev_t a);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_unexpected: got kind %0d cli %0d dat %h, required none",
                     a.kind, a.cli, a.dat);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL event_k%0d: got kind %0d cli %0d ip %h proto %h len %h dat %h, required kind %0d cli %0d ip %h proto %h len %h dat %h",
                         e.kind, a.kind, a.cli, a.ip, a.proto, a.len, a.dat,
                         e.kind, e.cli, e.ip, e.proto, e.len, e.dat);
            end
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin
        ev_t  a;
        logic prev_pend;
        prev_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cli_acc != '0) begin
                    own = idx(cli_acc);
                    got(ev(K_ACC, own, 8'd0));
                end
                if (tx_val) got(ev(K_BYTE, own, tx_dat));
                if (cli_done != '0) got(ev(K_DONE, idx(cli_done), 8'd0));
                if (cli_err != '0) got(ev(K_ERR, idx(cli_err), 8'd0));
                if (tx_pend && !prev_pend) begin
                    a       = ev(K_PEND, 0, 8'd0);
                    a.ip    = tx_ip;
                    a.proto = tx_proto;
                    a.len   = tx_len;
                    got(a);
                end
                if (cli_req != '0) begin
                    check("cli_req_owner", 64'(cli_req), 64'({{(N-1){1'b0}}, 1'b1} << own));
                end
            end
            prev_pend = tx_pend;
        end
    end

    task automatic push_hdr(input int c);
        ev_t e;
        e       = ev(K_PEND, 0, 8'd0);
        e.ip    = ip_a[c];
        e.proto = pr_a[c];
        e.len   = ln_a[c];
        exp_q.push_back(e);
    endtask

    task automatic push_pkt(input int c, input int nb, input logic [2:0] endk);
        push_hdr(c);
        exp_q.push_back(ev(K_ACC, c, 8'd0));
        for (int j = 0; j < nb; j++) begin
            exp_q.push_back(ev(K_BYTE, c, {4'(c), 4'(j)}));
        end
        exp_q.push_back(ev(endk, c, 8'd0));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pend;
        int n;
        n = 0;
        while (!tx_pend && n < 200) begin
            tick();
            n++;
        end
        check("tx_pend_wait", 64'(tx_pend), 64'd1);
    endtask

    // TX model. mode 0: done, 1: tx_err after nb bytes, 2: done+err together
    task automatic serve(input int busy_dly, input int nb, input int mode, input int extra);
        wait_pend();
        repeat (busy_dly) tick();
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        for (int j = 0; j < nb; j++) begin
            tx_req = 1'b1;
            tick();
            tx_req = 1'b0;
            tick();
        end
        if (mode == 1) begin
            tx_err = 1'b1;
            tick();
            tx_err = 1'b0;
            check("tx_pend_after_err", 64'(tx_pend), 64'd0);
        end else begin
            for (int j = 0; j < extra; j++) begin
                tx_req = 1'b1;
                #1;
                check("req_blocked", 64'({cli_req, tx_val}), 64'd0);
                tick();
                tx_req = 1'b0;
            end
            tick();
            tx_done = 1'b1;
            tx_err  = (mode == 2);
            tick();
            tx_done = 1'b0;
            tx_err  = 1'b0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c4;
        int c3;
        ev_t e;
        rst      = 1'b1;
        cli_pend = '0;
        tx_req   = 1'b0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        tx_err   = 1'b0;
        ip_a[0] = 32'hC0A8_010A; pr_a[0] = 8'd17; ln_a[0] = 16'd4;
        ip_a[1] = 32'h0A00_0001; pr_a[1] = 8'd6;  ln_a[1] = 16'd10;
        ip_a[2] = 32'h0808_0808; pr_a[2] = 8'd1;  ln_a[2] = 16'd1;
        ord = '{1, 2, 0, 1, 2, 0};
        if (PRIO) ord = '{0, 0, 0, 0, 0, 0};
        c3 = PRIO ? 0 : 2;
        c4 = PRIO ? 0 : 2;

        repeat (3) tick();
        check("rst_tx_pend", 64'(tx_pend), 64'd0);
        check("rst_tx_ip", 64'(tx_ip), 64'd0);
        check("rst_tx_proto", 64'(tx_proto), 64'd0);
        check("rst_tx_len", 64'(tx_len), 64'd0);
        check("rst_tx_val", 64'(tx_val), 64'd0);
        check("rst_cli_pulses", 64'({cli_req, cli_acc, cli_done, cli_err}), 64'd0);
        rst = 1'b0;
        tick();

        // Single packet from client 0
        push_pkt(0, 4, K_DONE);
        cli_pend = 3'b001;
        check("pend_latency_pre", 64'(tx_pend), 64'd0);
        tick();
        check("pend_latency", 64'(tx_pend), 64'd1);
        check("hdr_ip", 64'(tx_ip), 64'hC0A8_010A);
        check("hdr_proto", 64'(tx_proto), 64'h11);
        check("hdr_len", 64'(tx_len), 64'd4);
        cli_pend = 3'b000;
        serve(2, 4, 0, 0);

        // All clients pending for six packets
        for (int k = 0; k < 6; k++) push_pkt(ord[k], int'(ln_a[ord[k]]), K_DONE);
        cli_pend = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_pend();
            if (k == 5) cli_pend = 3'b000;
            serve(1, int'(ln_a[ord[k]]), 0, 0);
        end

        // tx_err mid-transfer on client 1
        push_hdr(1);
        exp_q.push_back(ev(K_ACC, 1, 8'd0));
        exp_q.push_back(ev(K_BYTE, 1, 8'h10));
        exp_q.push_back(ev(K_BYTE, 1, 8'h11));
        exp_q.push_back(ev(K_ERR, 1, 8'd0));
        push_pkt(c3, int'(ln_a[c3]), K_DONE);
        cli_pend = 3'b010;
        wait_pend();
        cli_pend = 3'b111;
        serve(1, 2, 1, 0);
        wait_pend();
        cli_pend = 3'b000;
        serve(1, int'(ln_a[c3]), 0, 0);

        // Timeout with tx_busy never asserted
        push_hdr(0);
        exp_q.push_back(ev(K_ERR, 0, 8'd0));
        push_pkt(c4, int'(ln_a[c4]), K_DONE);
        cli_pend = 3'b001;
        wait_pend();
        cli_pend = 3'b101;
        n = 0;
        while (cli_err == '0 && n < 300) begin
            tick();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd100);
        wait_pend();
        cli_pend = 3'b000;
        serve(1, int'(ln_a[c4]), 0, 0);

        // Zero-length packets: normal done, then done+err together
        ln_a[1] = 16'd0;
        ln_a[2] = 16'd0;
        push_pkt(1, 0, K_DONE);
        cli_pend = 3'b010;
        wait_pend();
        cli_pend = 3'b000;
        serve(1, 0, 0, 2);
        push_pkt(2, 0, K_ERR);
        cli_pend = 3'b100;
        wait_pend();
        cli_pend = 3'b000;
        serve(1, 0, 2, 0);

        repeat (5) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
